// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, port-select
// encoding and the default RAM depth.
package dmem_arbiter_pkg;

  // Number of data RAM words unless overridden at instantiation.
  localparam int unsigned DefaultDepth = 100;

  typedef enum logic [0:0] {
    StArb   = 1'b0,
    StClear = 1'b1
  } arb_state_e;

  // Bit position of each requester in the two-bit request/grant vectors.
  typedef enum logic [0:0] {
    SelCpu = 1'b0,
    SelDma = 1'b1
  } port_sel_e;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is the CPU, bit 1 the DMA/loader port.
// A lone requester wins at once; on contention the port that did not win
// last time is granted.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  port_sel_e  last,
  output logic [1:0] gnt
);

  // Combinational grant from the request vector and the last winner.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == SelDma) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one combinational-read RAM port between the CPU
// and a loader/debug (DMA) port with round-robin arbitration, range checking
// and registered read responses.
// Optional feature: define DMEM_ARB_CLEAR_EN to build the CLEAR state, which
// zeroes the whole RAM one word per cycle on clr_start. Without it clr_start
// is ignored and clr_busy is tied low.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  // CPU port
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  // Loader/debug port
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  // Memory clear control
  input  logic          clr_start,
  output logic          clr_busy,
  // Out-of-range access indication
  output logic          addr_err,
  // RAM port
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_WD,
  output logic          mem_WE,
  input  logic [DW-1:0] mem_RD
);

  localparam logic [AW-1:0] DepthAw = AW'(DEPTH);

  arb_state_e    state_q, state_d;
  port_sel_e     last_q;
  logic          arb_en;
  logic [1:0]    req_vec, gnt_vec;
  logic          any_gnt, sel_dma, sel_we, in_range;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          cpu_rvalid_q, dma_rvalid_q, addr_err_q;
  logic [DW-1:0] cpu_rdata_q, dma_rdata_q;

`ifdef DMEM_ARB_CLEAR_EN
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
`else
  logic unused_clr_start;
  assign unused_clr_start = clr_start;
`endif

  // Next-state logic; a clear request in ARB pre-empts arbitration that cycle.
  always_comb begin
    state_d  = state_q;
    arb_en   = reset && (state_q == StArb);
    clr_busy = 1'b0;
`ifdef DMEM_ARB_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StArb: begin
        if (clr_start) begin
          state_d   = StClear;
          clr_cnt_d = '0;
          arb_en    = 1'b0;
        end
      end
      StClear: begin
        // clr_start is ignored here so the sweep is never restarted.
        clr_busy = reset;
        if (clr_cnt_q == LastAddr) begin
          state_d   = StArb;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      default: state_d = StArb;
    endcase
`else
    state_d = StArb;
`endif
  end

  // FSM state register and clear counter; reset aborts any clear in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StArb;
`ifdef DMEM_ARB_CLEAR_EN
      clr_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
`ifdef DMEM_ARB_CLEAR_EN
      clr_cnt_q <= clr_cnt_d;
`endif
    end
  end

  assign req_vec = {dma_req, cpu_req} & {2{arb_en}};

  rr_arb2 u_rr_arb2 (
    .req  (req_vec),
    .last (last_q),
    .gnt  (gnt_vec)
  );

  assign cpu_gnt = gnt_vec[0];
  assign dma_gnt = gnt_vec[1];
  assign any_gnt = |gnt_vec;

  // Steer the granted port onto the RAM; CLEAR overrides with a zeroing write.
  always_comb begin
    sel_dma   = gnt_vec[1];
    sel_addr  = sel_dma ? dma_addr : cpu_addr;
    sel_wdata = sel_dma ? dma_wdata : cpu_wdata;
    sel_we    = sel_dma ? dma_we : cpu_we;
    in_range  = (sel_addr < DepthAw);
    mem_A     = '0;
    mem_WD    = '0;
    mem_WE    = 1'b0;
    if (any_gnt) begin
      mem_A  = sel_addr;
      mem_WD = sel_wdata;
      mem_WE = sel_we && in_range;
    end
`ifdef DMEM_ARB_CLEAR_EN
    if (clr_busy) begin
      mem_A  = clr_cnt_q;
      mem_WD = '0;
      mem_WE = 1'b1;
    end
`endif
  end

  // Read responses, range error pulse and round-robin history.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q       <= SelDma;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      cpu_rvalid_q <= cpu_gnt && !cpu_we;
      dma_rvalid_q <= dma_gnt && !dma_we;
      addr_err_q   <= any_gnt && !in_range;
      if (any_gnt) begin
        last_q <= sel_dma ? SelDma : SelCpu;
      end
      // Out-of-range reads still respond, but with zero data.
      if (cpu_gnt && !cpu_we) begin
        cpu_rdata_q <= in_range ? mem_RD : '0;
      end
      if (dma_gnt && !dma_we) begin
        dma_rdata_q <= in_range ? mem_RD : '0;
      end
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rdata_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the arbiter and RAM.
module tb_dmem_arbiter;

  localparam int unsigned DEPTH = 100;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
`ifdef DMEM_ARB_CLEAR_EN
  localparam bit ClearEn = 1'b1;
`else
  localparam bit ClearEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          clr_start, clr_busy, addr_err;
  logic [AW-1:0] mem_A;
  logic [DW-1:0] mem_WD, mem_RD;
  logic          mem_WE;

  // RAM seen by the DUT, and the model's idea of what it should contain.
  logic [DW-1:0] ram  [DEPTH];
  logic [DW-1:0] gold [DEPTH];

  always #5 clk = ~clk;

  assign mem_RD = (mem_A < DEPTH) ? ram[mem_A[6:0]] : '0;

  dmem_arbiter #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .clr_start  (clr_start),
    .clr_busy   (clr_busy),
    .addr_err   (addr_err),
    .mem_A      (mem_A),
    .mem_WD     (mem_WD),
    .mem_WE     (mem_WE),
    .mem_RD     (mem_RD)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus for the next cycle.
  bit            s_rst_n, s_cpu_req, s_cpu_we, s_dma_req, s_dma_we, s_clr;
  logic [AW-1:0] s_cpu_addr, s_dma_addr;
  logic [DW-1:0] s_cpu_wd, s_dma_wd;

  // Model: words left to clear (0 = arbitrating), contention priority, and
  // the registered outputs expected after the coming edge.
  int unsigned   m_clear_left = 0;
  bit            m_dma_first  = 1'b0;
  bit            regs_known   = 1'b0;
  logic          e_cpu_rvalid, e_dma_rvalid, e_addr_err;
  logic [DW-1:0] e_cpu_rdata, e_dma_rdata;

  task automatic idle();
    s_rst_n   = 1'b1;
    s_cpu_req = 1'b0;
    s_cpu_we  = 1'b0;
    s_dma_req = 1'b0;
    s_dma_we  = 1'b0;
    s_clr     = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram[i]  = $urandom | 32'h1;
      gold[i] = ram[i];
    end
  endtask

  // One clock cycle: check last edge's registered outputs, apply stimulus,
  // check the combinational outputs against the model, advance the model.
  task automatic step();
    bit            e_cg, e_dg, e_we, e_busy, we;
    logic [AW-1:0] e_a, a;
    logic [DW-1:0] wd;
    @(negedge clk);
    if (regs_known) begin
      check_eq("cpu_rvalid", cpu_rvalid, e_cpu_rvalid);
      check_eq("cpu_rdata", cpu_rdata, e_cpu_rdata);
      check_eq("dma_rvalid", dma_rvalid, e_dma_rvalid);
      check_eq("dma_rdata", dma_rdata, e_dma_rdata);
      check_eq("addr_err", addr_err, e_addr_err);
    end
    reset     = s_rst_n;
    cpu_req   = s_cpu_req;
    cpu_we    = s_cpu_we;
    cpu_addr  = s_cpu_addr;
    cpu_wdata = s_cpu_wd;
    dma_req   = s_dma_req;
    dma_we    = s_dma_we;
    dma_addr  = s_dma_addr;
    dma_wdata = s_dma_wd;
    clr_start = s_clr;
    #1;
    e_cg = 1'b0; e_dg = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_a = '0;
    if (!s_rst_n) begin
      m_clear_left = 0;
      m_dma_first  = 1'b0;
      e_cpu_rvalid = 1'b0; e_dma_rvalid = 1'b0; e_addr_err = 1'b0;
      e_cpu_rdata  = '0;   e_dma_rdata  = '0;
    end else if (m_clear_left > 0) begin
      e_busy = 1'b1;
      e_we   = 1'b1;
      e_a    = AW'(DEPTH - m_clear_left);
      gold[e_a[6:0]] = '0;
      m_clear_left--;
      e_cpu_rvalid = 1'b0; e_dma_rvalid = 1'b0; e_addr_err = 1'b0;
    end else if (s_clr && ClearEn) begin
      m_clear_left = DEPTH;
      e_cpu_rvalid = 1'b0; e_dma_rvalid = 1'b0; e_addr_err = 1'b0;
    end else begin
      e_cg = s_cpu_req && !(s_dma_req && m_dma_first);
      e_dg = s_dma_req && !e_cg;
      e_cpu_rvalid = 1'b0; e_dma_rvalid = 1'b0; e_addr_err = 1'b0;
      if (e_cg || e_dg) begin
        a  = e_cg ? s_cpu_addr : s_dma_addr;
        we = e_cg ? s_cpu_we : s_dma_we;
        wd = e_cg ? s_cpu_wd : s_dma_wd;
        e_a = a;
        e_addr_err = (a >= DEPTH);
        if (we) begin
          if (a < DEPTH) begin
            e_we = 1'b1;
            gold[a[6:0]] = wd;
          end
        end else if (e_cg) begin
          e_cpu_rvalid = 1'b1;
          e_cpu_rdata  = (a < DEPTH) ? gold[a[6:0]] : '0;
        end else begin
          e_dma_rvalid = 1'b1;
          e_dma_rdata  = (a < DEPTH) ? gold[a[6:0]] : '0;
        end
        m_dma_first = e_cg;
      end
    end
    regs_known = 1'b1;
    check_eq("cpu_gnt", cpu_gnt, e_cg);
    check_eq("dma_gnt", dma_gnt, e_dg);
    check_eq("mem_WE", mem_WE, e_we);
    check_eq("clr_busy", clr_busy, e_busy);
    if (s_rst_n) check_eq("mem_A", mem_A, e_a);
    if (e_we) check_eq("mem_WD", mem_WD, e_busy ? '0 : wd);
    // The RAM takes the write now; no read is registered in a write cycle.
    if (mem_WE && mem_A < DEPTH) ram[mem_A[6:0]] = mem_WD;
  endtask

  int unsigned busy_cycles;
  logic [DW-1:0] kept_word;

  initial begin
    idle();
    s_cpu_addr = '0; s_dma_addr = '0; s_cpu_wd = '0; s_dma_wd = '0;
    preload();
    ram[5]  = 32'hDEADBEEF;
    gold[5] = 32'hDEADBEEF;

    s_rst_n = 1'b0; step(); step();
    idle();
    step();

    // CPU-only read of a known word.
    s_cpu_req = 1'b1; s_cpu_addr = 5; step();
    check_eq("rd5_gnt_same_cycle", cpu_gnt, 1'b1);
    idle(); step();
    check_eq("rd5_rvalid", cpu_rvalid, 1'b1);
    check_eq("rd5_rdata", cpu_rdata, 32'hDEADBEEF);
    step();
    check_eq("rd5_rvalid_one_cycle", cpu_rvalid, 1'b0);

    // Contention right after reset alternates starting with the CPU.
    s_rst_n = 1'b0; step(); idle();
    for (int k = 0; k < 4; k++) begin
      s_cpu_req = 1'b1; s_dma_req = 1'b1;
      s_cpu_addr = $urandom_range(0, 99); s_dma_addr = $urandom_range(0, 99);
      step();
      check_eq("rr_cpu_gnt", cpu_gnt, logic'(k % 2 == 0));
    end

    // Out-of-range DMA write is dropped and flagged.
    idle();
    s_dma_req = 1'b1; s_dma_we = 1'b1; s_dma_addr = 120; s_dma_wd = 32'h1234; step();
    check_eq("oor_dma_gnt", dma_gnt, 1'b1);
    check_eq("oor_mem_we", mem_WE, 1'b0);
    idle(); step();
    check_eq("oor_addr_err", addr_err, 1'b1);
    step();
    check_eq("oor_addr_err_pulse", addr_err, 1'b0);

`ifdef DMEM_ARB_CLEAR_EN
    // Full clear with both ports requesting throughout; a mid-clear
    // clr_start must not restart the sweep.
    preload();
    idle();
    s_cpu_req = 1'b1; s_dma_req = 1'b1; s_cpu_addr = 3; s_dma_addr = 9;
    s_clr = 1'b1; step();
    busy_cycles = 0;
    for (int k = 0; k < 150; k++) begin
      s_clr = (k == 50);
      step();
      if (clr_busy) busy_cycles++;
      else if (busy_cycles != 0) break;
    end
    check_eq("clear_busy_cycles", busy_cycles, 100);
    check_eq("clear_resume_gnt", cpu_gnt || dma_gnt, 1'b1);
    for (int i = 0; i < int'(DEPTH); i++) check_eq("clear_word_zero", ram[i], '0);

    // Reset aborts a clear part-way through.
    preload();
    kept_word = ram[40];
    idle(); s_clr = 1'b1; step();
    idle();
    for (int k = 0; k < 40; k++) step();
    s_rst_n = 1'b0; step();
    idle(); step();
    check_eq("abort_clr_busy", clr_busy, 1'b0);
    check_eq("abort_word39", ram[39], '0);
    check_eq("abort_word40", ram[40], kept_word);
    for (int i = 0; i < int'(DEPTH); i++) check_eq("abort_word", ram[i], gold[i]);
`else
    // Clear request has no effect in this build.
    idle();
    s_cpu_req = 1'b1; s_cpu_addr = 7; s_clr = 1'b1; step();
    check_eq("clr_ignored_gnt", cpu_gnt, 1'b1);
    idle(); step();
    check_eq("clr_ignored_busy", clr_busy, 1'b0);
`endif

    // Randomized traffic, with occasional resets and clear requests.
    for (int i = 0; i < 3000; i++) begin
      s_rst_n    = ($urandom_range(0, 99) != 0);
      s_cpu_req  = 1'($urandom_range(0, 1));
      s_cpu_we   = ($urandom_range(0, 2) == 0);
      s_cpu_addr = $urandom_range(0, 119);
      s_cpu_wd   = $urandom;
      s_dma_req  = 1'($urandom_range(0, 1));
      s_dma_we   = ($urandom_range(0, 2) == 0);
      s_dma_addr = $urandom_range(0, 119);
      s_dma_wd   = $urandom;
      s_clr      = ($urandom_range(0, 199) == 0);
      step();
    end
    idle(); step(); step();

    for (int i = 0; i < int'(DEPTH); i++) check_eq("ram_final", ram[i], gold[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 100, meaning the number of data RAM words.
REQ-002 The block SHALL have parameter AW, default 32, meaning the address width.
REQ-003 The block SHALL have parameter DW, default 32, meaning the data width.
REQ-004 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-005 reset  in  1  synchronous, active-low reset, sampled on posedge clk.
REQ-006 cpu_req, cpu_we  in  1 each  CPU access request and write flag.
REQ-007 cpu_addr  in  AW, cpu_wdata  in  DW  CPU word address and write data.
REQ-008 cpu_gnt  out  1, cpu_rvalid  out  1, cpu_rdata  out  DW  CPU grant, read-valid and read data.
REQ-009 dma_req, dma_we  in  1 each; dma_addr  in  AW; dma_wdata  in  DW  loader/debug port request, mirroring the CPU port.
REQ-010 dma_gnt, dma_rvalid  out  1; dma_rdata  out  DW  loader port responses.
REQ-011 clr_start  in  1; clr_busy  out  1  memory-clear request and busy flag.
REQ-012 addr_err  out  1  one-cycle pulse on an out-of-range granted access.
REQ-013 mem_A  out  AW; mem_WD  out  DW; mem_WE  out  1; mem_RD  in  DW  single RAM port (combinational read, write on posedge).

Function
REQ-014 The FSM SHALL have exactly two states, ARB and CLEAR.
REQ-015 In ARB, at most one requester SHALL be granted per cycle; gnt is combinational from req and the arbitration pointer.
REQ-016 With a single active requester, that requester SHALL be granted in the same cycle.
REQ-017 With both requesting, the requester not granted last SHALL win (round-robin); last_winner SHALL update only on a grant.
REQ-018 mem_A/mem_WD/mem_WE SHALL mirror the granted port; with no grant, mem_WE=0 and mem_A=0.
REQ-019 On a granted read, mem_RD SHALL be registered into that port's rdata, with rvalid=1 for exactly the following cycle.
REQ-020 On a granted write, rvalid SHALL stay 0; the write SHALL occur at that edge.
REQ-021 An address >= DEPTH SHALL suppress mem_WE, return rdata=0 with rvalid as normal, and pulse addr_err the next cycle.
REQ-022 An ungranted port SHALL hold its rdata value.
REQ-023 clr_start=1 in ARB SHALL enter CLEAR at the next edge and take precedence over same-cycle requests, which are not granted.
REQ-024 In CLEAR, clr_busy=1, both gnt=0, mem_WE=1, mem_WD=0, mem_A=clr_cnt; clr_cnt SHALL step 0..DEPTH-1, one word per cycle.
REQ-025 After writing address DEPTH-1, the FSM SHALL return to ARB; CLEAR lasts exactly DEPTH cycles.
REQ-026 clr_start while in CLEAR SHALL be ignored and SHALL NOT restart the counter.

Reset
REQ-027 On reset=0 at posedge, the block SHALL set state=ARB, clr_cnt=0, last_winner=DMA (so the CPU wins the first contention), rvalids=0, rdatas=0 and addr_err=0.
REQ-028 A reset during CLEAR SHALL abort the clear; words already zeroed stay zeroed.
REQ-029 While reset=0, combinational outputs SHALL be forced inactive: gnt=0, mem_WE=0, clr_busy=0.

Configuration
REQ-030 With macro DMEM_ARB_CLEAR_EN defined, the CLEAR state, clr_cnt and clr_busy logic SHALL be present as specified.
REQ-031 Without DMEM_ARB_CLEAR_EN, clr_start SHALL be ignored, clr_busy SHALL be tied 0, and the FSM SHALL remain in ARB.

Structure
REQ-032 A shared package SHALL hold the state encoding (ARB, CLEAR), the port-select encoding (CPU, DMA) and the DEPTH default.
REQ-033 Round-robin selection SHALL live in one sub-module, rr_arb2, with inputs req[1:0] and last and output gnt[1:0].

Verification
REQ-034 CPU-only read at addr 5 holding 0xDEADBEEF -> cpu_gnt=1 in the same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF.
REQ-035 Both ports request for 4 cycles after reset -> grants go CPU, DMA, CPU, DMA.
REQ-036 DMA write of 0x1234 to addr 120 -> mem_WE=0, addr_err pulses 1 cycle; RAM unchanged.
REQ-037 RAM preloaded nonzero, clr_start pulsed -> clr_busy high exactly 100 cycles, all words 0, requests stalled, then normal grants resume.
REQ-038 reset=0 asserted at clr_cnt=40 -> at release state=ARB, clr_busy=0, words 0..39 zero, words 40..99 unchanged.
